// File: rtl/u109_pci_pkg.sv
// Shared definitions for the U109 PCI bridge target path: command codes,
// target FSM states, decode speed and the AD <-> local-bus byte lane helpers.
package u109_pci_pkg;

    localparam logic [7:0] WINDOW_BASE = 8'h00;
    localparam int         RETRY_LIMIT = 16;

    localparam logic [3:0] CMD_MEM_READ      = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE     = 4'b0111;
    localparam logic [3:0] CMD_MEM_READ_MULT = 4'b1100;
    localparam logic [3:0] CMD_MEM_READ_LINE = 4'b1110;
    localparam logic [3:0] CMD_MEM_WRITE_INV = 4'b1111;

    // Medium decode: DEVSELn asserts on the 2nd edge after the address phase.
    localparam int DEVSEL_DELAY = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_BUSY_OTHER,
        ST_WAIT_LOCAL,
        ST_DATA,
        ST_TURNAROUND
    } tgt_state_t;

    // Little-endian AD bus <-> big-endian local bus.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Active-low PCI byte enables to active-high local enables, lane order reversed.
    function automatic logic [3:0] be_from_cbe(input logic [3:0] cbe);
        return {~cbe[0], ~cbe[1], ~cbe[2], ~cbe[3]};
    endfunction

endpackage

// File: rtl/u109_target_decode.sv
// Window and command hit decode from the latched address-phase AD[31:24] and command.
module u109_target_decode (
    input  logic [7:0] addr_hi,
    input  logic [3:0] cmd,
    output logic       hit
);
    import u109_pci_pkg::*;

    logic cmd_ok;

    // Only memory-space commands that map onto a local longword access are claimed.
    always_comb begin
        cmd_ok = 1'b0;
        case (cmd)
            CMD_MEM_READ, CMD_MEM_WRITE, CMD_MEM_READ_MULT,
            CMD_MEM_READ_LINE, CMD_MEM_WRITE_INV: cmd_ok = 1'b1;
            default:                              cmd_ok = 1'b0;
        endcase
    end

    assign hit = cmd_ok && (addr_hi == WINDOW_BASE);

endmodule

// File: rtl/u109_pci_target.sv
// U109 PCI target responder: claims DMA cycles into the Amiga window, runs one
// local access per data phase and byte-swaps between AD and the local bus.
// Build option: define TARGET_BURST_EN for multi-phase bursts up to a 1 KB
// boundary; without it every transaction disconnects with data on phase one.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | waiting for an address phase on an idle bus
// ST_DECODE     | address latched, medium-decode delay before claiming
// ST_BUSY_OTHER | transaction not ours, wait for bus idle
// ST_WAIT_LOCAL | claimed, local access in flight (or waiting for write data)
// ST_DATA       | TRDYn and/or STOPn driven, waiting for completion / FRAMEn
// ST_TURNAROUND | controls driven high for one clock before release
module u109_pci_target (
    input  logic        CLK33,
    input  logic        RESETn,
    input  logic        FRAMEn,
    input  logic        IRDYn,
    input  logic [3:0]  CBE,
    input  logic [31:0] AD_IN,
    output logic        DEVSELn,
    output logic        TRDYn,
    output logic        STOPn,
    output logic        TGT_OE,
    output logic [31:0] AD_OUT,
    output logic        AD_OE,
    output logic        L_REQ,
    input  logic        L_ACK,
    output logic [29:0] L_ADDR,
    output logic        L_RnW,
    output logic [3:0]  L_BE,
    output logic [31:0] L_WDATA,
    input  logic [31:0] L_RDATA,
    output logic        TGT_BUSY
);
    import u109_pci_pkg::*;

`ifdef TARGET_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    tgt_state_t  state, state_next;
    logic        bus_idle_q;
    logic [1:0]  ad_lo_q;
    logic [3:0]  cmd_q;
    logic [1:0]  dec_cnt;
    logic [4:0]  lat_cnt;
    logic        first_q;
    logic        hit;
    logic        ack_ok, complete, disc;
    logic        devsel_d, trdy_d, stop_d, tgt_oe_d, ad_oe_d, l_req_d, busy_d;
    logic        addr_load, addr_inc, wdata_load, be_load, rdata_load, first_set;

    u109_target_decode u_decode (
        .addr_hi (L_ADDR[29:22]),
        .cmd     (cmd_q),
        .hit     (hit)
    );

    // A late acknowledge after a retry finds L_REQ low and is dropped here.
    assign ack_ok   = L_ACK && L_REQ;
    assign complete = !IRDYn && !TRDYn;
    assign disc     = !BURST_EN || (L_ADDR[7:0] == 8'hFF) || (ad_lo_q != 2'b00);

    // Next-state and next values of the registered bus/local controls.
    always_comb begin
        state_next = state;
        devsel_d   = DEVSELn;
        trdy_d     = TRDYn;
        stop_d     = STOPn;
        tgt_oe_d   = TGT_OE;
        ad_oe_d    = AD_OE;
        l_req_d    = L_REQ;
        busy_d     = TGT_BUSY;
        addr_load  = 1'b0;
        addr_inc   = 1'b0;
        wdata_load = 1'b0;
        be_load    = 1'b0;
        rdata_load = 1'b0;
        first_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!FRAMEn && bus_idle_q) begin
                    addr_load  = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_cnt == 2'(DEVSEL_DELAY - 1)) begin
                    if (hit) begin
                        devsel_d   = 1'b0;
                        tgt_oe_d   = 1'b1;
                        busy_d     = 1'b1;
                        state_next = ST_WAIT_LOCAL;
                        if (L_RnW) begin
                            l_req_d = 1'b1;
                            be_load = 1'b1;
                        end
                    end else begin
                        state_next = ST_BUSY_OTHER;
                    end
                end
            end
            ST_BUSY_OTHER: begin
                if (FRAMEn && IRDYn) state_next = ST_IDLE;
            end
            ST_WAIT_LOCAL: begin
                if (ack_ok) begin
                    l_req_d    = 1'b0;
                    trdy_d     = 1'b0;
                    stop_d     = !disc;
                    first_set  = 1'b1;
                    state_next = ST_DATA;
                    if (L_RnW) begin
                        rdata_load = 1'b1;
                        ad_oe_d    = 1'b1;
                    end
                end else if (!first_q && lat_cnt == 5'(RETRY_LIMIT - 1)) begin
                    // Target retry: STOPn without TRDYn, local request cancelled.
                    l_req_d    = 1'b0;
                    stop_d     = 1'b0;
                    state_next = ST_DATA;
                end else if (!L_RnW && !L_REQ && !IRDYn) begin
                    l_req_d    = 1'b1;
                    wdata_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (TRDYn) begin
                    // STOPn held without data until the initiator drops FRAMEn.
                    if (FRAMEn) begin
                        devsel_d   = 1'b1;
                        stop_d     = 1'b1;
                        state_next = ST_TURNAROUND;
                    end
                end else if (complete) begin
                    if (FRAMEn) begin
                        devsel_d   = 1'b1;
                        trdy_d     = 1'b1;
                        stop_d     = 1'b1;
                        state_next = ST_TURNAROUND;
                    end else if (!STOPn) begin
                        trdy_d = 1'b1;
                    end else begin
                        trdy_d     = 1'b1;
                        addr_inc   = 1'b1;
                        state_next = ST_WAIT_LOCAL;
                        if (L_RnW) begin
                            l_req_d = 1'b1;
                            be_load = 1'b1;
                        end
                    end
                end
            end
            ST_TURNAROUND: begin
                tgt_oe_d   = 1'b0;
                ad_oe_d    = 1'b0;
                busy_d     = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and registered control outputs.
    always_ff @(posedge CLK33 or negedge RESETn) begin
        if (!RESETn) begin
            state    <= ST_IDLE;
            DEVSELn  <= 1'b1;
            TRDYn    <= 1'b1;
            STOPn    <= 1'b1;
            TGT_OE   <= 1'b0;
            AD_OE    <= 1'b0;
            L_REQ    <= 1'b0;
            TGT_BUSY <= 1'b0;
        end else begin
            state    <= state_next;
            DEVSELn  <= devsel_d;
            TRDYn    <= trdy_d;
            STOPn    <= stop_d;
            TGT_OE   <= tgt_oe_d;
            AD_OE    <= ad_oe_d;
            L_REQ    <= l_req_d;
            TGT_BUSY <= busy_d;
        end
    end

    // Address/data latches, decode delay and first-data latency counter.
    always_ff @(posedge CLK33 or negedge RESETn) begin
        if (!RESETn) begin
            bus_idle_q <= 1'b1;
            L_ADDR     <= '0;
            ad_lo_q    <= '0;
            cmd_q      <= '0;
            L_RnW      <= 1'b1;
            L_WDATA    <= '0;
            L_BE       <= '0;
            AD_OUT     <= '0;
            dec_cnt    <= '0;
            lat_cnt    <= '0;
            first_q    <= 1'b0;
        end else begin
            bus_idle_q <= FRAMEn && IRDYn;
            if (addr_load) begin
                L_ADDR  <= AD_IN[31:2];
                ad_lo_q <= AD_IN[1:0];
                cmd_q   <= CBE;
                L_RnW   <= ~CBE[0];
            end else if (addr_inc) begin
                L_ADDR <= L_ADDR + 30'd1;
            end
            if (wdata_load) begin
                L_WDATA <= byte_swap(AD_IN);
                L_BE    <= be_from_cbe(CBE);
            end else if (be_load) begin
                L_BE <= be_from_cbe(CBE);
            end
            if (rdata_load) AD_OUT <= byte_swap(L_RDATA);
            dec_cnt <= (state == ST_DECODE) ? dec_cnt + 2'd1 : 2'd0;
            if (state == ST_IDLE)
                lat_cnt <= '0;
            else if (state == ST_WAIT_LOCAL && !first_q && !ack_ok)
                lat_cnt <= lat_cnt + 5'd1;
            if (state == ST_IDLE)
                first_q <= 1'b0;
            else if (first_set)
                first_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_u109_pci_target.sv
// Directed bench for u109_pci_target: drives PCI master and local-side
// stimulus on the falling edge and samples outputs there.
module tb_u109_pci_target;

    logic        CLK33 = 1'b0;
    logic        RESETn, FRAMEn, IRDYn, L_ACK;
    logic [3:0]  CBE;
    logic [31:0] AD_IN, L_RDATA;
    logic        DEVSELn, TRDYn, STOPn, TGT_OE, AD_OE, L_REQ, L_RnW, TGT_BUSY;
    logic [31:0] AD_OUT, L_WDATA;
    logic [29:0] L_ADDR;
    logic [3:0]  L_BE;

    int checks   = 0;
    int failures = 0;

    always #5 CLK33 = ~CLK33;

    u109_pci_target dut (
        .CLK33(CLK33), .RESETn(RESETn), .FRAMEn(FRAMEn), .IRDYn(IRDYn),
        .CBE(CBE), .AD_IN(AD_IN), .DEVSELn(DEVSELn), .TRDYn(TRDYn),
        .STOPn(STOPn), .TGT_OE(TGT_OE), .AD_OUT(AD_OUT), .AD_OE(AD_OE),
        .L_REQ(L_REQ), .L_ACK(L_ACK), .L_ADDR(L_ADDR), .L_RnW(L_RnW),
        .L_BE(L_BE), .L_WDATA(L_WDATA), .L_RDATA(L_RDATA), .TGT_BUSY(TGT_BUSY)
    );

    task automatic tick;
        @(posedge CLK33);
        @(negedge CLK33);
    endtask

    // Drives one address phase; the edge inside is the address-phase edge.
    task automatic addr_phase(input logic [31:0] addr, input logic [3:0] cmd);
        FRAMEn = 1'b0; IRDYn = 1'b1; AD_IN = addr; CBE = cmd;
        tick();
    endtask

    task automatic test_reset;
        RESETn = 1'b0; FRAMEn = 1'b1; IRDYn = 1'b1; CBE = 4'h0; AD_IN = '0;
        L_ACK = 1'b0; L_RDATA = '0;
        tick(); tick();
        checks++; if ({DEVSELn, TRDYn, STOPn, TGT_OE, AD_OE, L_REQ, L_RnW, TGT_BUSY} !== 8'b1110_0010) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=%b", {DEVSELn, TRDYn, STOPn, TGT_OE, AD_OE, L_REQ, L_RnW, TGT_BUSY}, 8'b1110_0010); end
        checks++; if (L_ADDR !== 30'h0 || L_BE !== 4'h0 || L_WDATA !== 32'h0 || AD_OUT !== 32'h0) begin
            failures++; $display("FAIL reset_data got addr=%h be=%h wd=%h ad=%h exp all zero", L_ADDR, L_BE, L_WDATA, AD_OUT); end
        RESETn = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single_read;
        logic exp_stop;
`ifdef TARGET_BURST_EN
        exp_stop = 1'b1;
`else
        exp_stop = 1'b0;
`endif
        addr_phase(32'h0000_1000, 4'b0110);
        FRAMEn = 1'b1; IRDYn = 1'b0; CBE = 4'b0000; AD_IN = '0;
        tick();
        checks++; if (DEVSELn !== 1'b1) begin
            failures++; $display("FAIL rd_devsel_edge1 got=%b exp=1", DEVSELn); end
        tick();
        checks++; if ({DEVSELn, TGT_OE, L_REQ, TGT_BUSY, L_RnW} !== 5'b01111) begin
            failures++; $display("FAIL rd_claim got=%b exp=01111", {DEVSELn, TGT_OE, L_REQ, TGT_BUSY, L_RnW}); end
        checks++; if (L_ADDR !== 30'h400) begin
            failures++; $display("FAIL rd_addr got=%h exp=400", L_ADDR); end
        tick(); tick();
        checks++; if (TRDYn !== 1'b1 || L_REQ !== 1'b1) begin
            failures++; $display("FAIL rd_wait got trdy=%b req=%b exp trdy=1 req=1", TRDYn, L_REQ); end
        L_ACK = 1'b1; L_RDATA = 32'h1122_3344;
        tick();
        L_ACK = 1'b0;
        checks++; if ({TRDYn, AD_OE, L_REQ, STOPn} !== {3'b010, exp_stop}) begin
            failures++; $display("FAIL rd_data_ctrl got=%b exp=%b", {TRDYn, AD_OE, L_REQ, STOPn}, {3'b010, exp_stop}); end
        checks++; if (AD_OUT !== 32'h4433_2211) begin
            failures++; $display("FAIL rd_ad_out got=%h exp=44332211", AD_OUT); end
        tick();
        IRDYn = 1'b1;
        checks++; if ({DEVSELn, TRDYn, STOPn, TGT_OE, TGT_BUSY} !== 5'b11111) begin
            failures++; $display("FAIL rd_turnaround got=%b exp=11111", {DEVSELn, TRDYn, STOPn, TGT_OE, TGT_BUSY}); end
        tick();
        checks++; if ({TGT_OE, AD_OE, TGT_BUSY} !== 3'b000) begin
            failures++; $display("FAIL rd_release got=%b exp=000", {TGT_OE, AD_OE, TGT_BUSY}); end
    endtask

    task automatic test_miss;
        logic [31:0] addrs [2];
        logic [3:0]  cmds  [2];
        addrs[0] = 32'h4000_0000; cmds[0] = 4'b0110;
        addrs[1] = 32'h0000_1000; cmds[1] = 4'b0010;
        for (int p = 0; p < 2; p++) begin
            addr_phase(addrs[p], cmds[p]);
            FRAMEn = 1'b0; IRDYn = 1'b0; CBE = 4'h0;
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++; if ({DEVSELn, TGT_OE, TGT_BUSY, L_REQ} !== 4'b1000) begin
                    failures++; $display("FAIL miss%0d_clk%0d got=%b exp=1000", p, k, {DEVSELn, TGT_OE, TGT_BUSY, L_REQ}); end
            end
            FRAMEn = 1'b1;
            tick();
            IRDYn = 1'b1;
            tick();
        end
    endtask

    task automatic test_retry;
        int n;
        addr_phase(32'h0000_2000, 4'b0110);
        FRAMEn = 1'b0; IRDYn = 1'b0; CBE = 4'h0;
        tick(); tick();
        checks++; if ({DEVSELn, L_REQ} !== 2'b01) begin
            failures++; $display("FAIL retry_claim got=%b exp=01", {DEVSELn, L_REQ}); end
        n = 0;
        while (STOPn !== 1'b0 && n < 40) begin tick(); n++; end
        checks++; if (n !== 16) begin
            failures++; $display("FAIL retry_latency got=%0d exp=16", n); end
        checks++; if ({TRDYn, L_REQ, STOPn} !== 3'b100) begin
            failures++; $display("FAIL retry_ctrl got=%b exp=100", {TRDYn, L_REQ, STOPn}); end
        L_ACK = 1'b1; L_RDATA = 32'hDEAD_BEEF;
        tick();
        L_ACK = 1'b0;
        checks++; if ({TRDYn, AD_OE, STOPn} !== 3'b100 || AD_OUT !== 32'h4433_2211) begin
            failures++; $display("FAIL retry_late_ack got=%b ad=%h exp=100 ad=44332211", {TRDYn, AD_OE, STOPn}, AD_OUT); end
        FRAMEn = 1'b1;
        tick();
        IRDYn = 1'b1;
        checks++; if ({DEVSELn, STOPn, TGT_OE} !== 3'b111) begin
            failures++; $display("FAIL retry_turnaround got=%b exp=111", {DEVSELn, STOPn, TGT_OE}); end
        tick();
        checks++; if ({TGT_OE, TGT_BUSY} !== 2'b00) begin
            failures++; $display("FAIL retry_release got=%b exp=00", {TGT_OE, TGT_BUSY}); end
    endtask

`ifdef TARGET_BURST_EN
    task automatic test_burst_write;
        logic [31:0] wd  [4];
        logic [31:0] exp [4];
        int n;
        wd[0] = 32'h0102_0304; exp[0] = 32'h0403_0201;
        wd[1] = 32'h0506_0708; exp[1] = 32'h0807_0605;
        wd[2] = 32'h090A_0B0C; exp[2] = 32'h0C0B_0A09;
        wd[3] = 32'h0D0E_0F10; exp[3] = 32'h100F_0E0D;
        addr_phase(32'h0000_0F00, 4'b0111);
        for (int i = 0; i < 4; i++) begin
            IRDYn = 1'b0; AD_IN = wd[i]; CBE = 4'b0000; FRAMEn = (i == 3);
            n = 0;
            while (L_REQ !== 1'b1 && n < 10) begin tick(); n++; end
            checks++; if (L_REQ !== 1'b1 || L_ADDR !== 30'h3C0 + 30'(i) || L_WDATA !== exp[i] || L_BE !== 4'hF || L_RnW !== 1'b0) begin
                failures++; $display("FAIL bw_phase%0d got req=%b addr=%h wd=%h be=%h rnw=%b exp req=1 addr=%h wd=%h be=f rnw=0",
                    i, L_REQ, L_ADDR, L_WDATA, L_BE, L_RnW, 30'h3C0 + 30'(i), exp[i]); end
            L_ACK = 1'b1;
            tick();
            L_ACK = 1'b0;
            checks++; if ({TRDYn, STOPn} !== 2'b01) begin
                failures++; $display("FAIL bw_trdy%0d got=%b exp=01", i, {TRDYn, STOPn}); end
            tick();
        end
        IRDYn = 1'b1;
        checks++; if ({DEVSELn, TRDYn, STOPn} !== 3'b111) begin
            failures++; $display("FAIL bw_turnaround got=%b exp=111", {DEVSELn, TRDYn, STOPn}); end
        tick();
        checks++; if (TGT_OE !== 1'b0) begin
            failures++; $display("FAIL bw_release got=%b exp=0", TGT_OE); end
    endtask

    task automatic test_burst_read;
        addr_phase(32'h0000_03F8, 4'b0110);
        FRAMEn = 1'b0; IRDYn = 1'b0; CBE = 4'h0;
        tick(); tick();
        checks++; if (L_REQ !== 1'b1 || L_ADDR !== 30'hFE) begin
            failures++; $display("FAIL br_first got req=%b addr=%h exp req=1 addr=fe", L_REQ, L_ADDR); end
        L_ACK = 1'b1; L_RDATA = 32'hAABB_CCDD;
        tick();
        L_ACK = 1'b0;
        checks++; if ({TRDYn, STOPn} !== 2'b01 || AD_OUT !== 32'hDDCC_BBAA) begin
            failures++; $display("FAIL br_phase0 got=%b ad=%h exp=01 ad=ddccbbaa", {TRDYn, STOPn}, AD_OUT); end
        tick();
        checks++; if (TRDYn !== 1'b1 || L_REQ !== 1'b1 || L_ADDR !== 30'hFF) begin
            failures++; $display("FAIL br_next got trdy=%b req=%b addr=%h exp trdy=1 req=1 addr=ff", TRDYn, L_REQ, L_ADDR); end
        FRAMEn = 1'b1;
        L_ACK = 1'b1; L_RDATA = 32'h0123_4567;
        tick();
        L_ACK = 1'b0;
        checks++; if ({TRDYn, STOPn} !== 2'b00 || AD_OUT !== 32'h6745_2301) begin
            failures++; $display("FAIL br_boundary got=%b ad=%h exp=00 ad=67452301", {TRDYn, STOPn}, AD_OUT); end
        tick();
        IRDYn = 1'b1;
        checks++; if ({DEVSELn, TRDYn, STOPn} !== 3'b111) begin
            failures++; $display("FAIL br_turnaround got=%b exp=111", {DEVSELn, TRDYn, STOPn}); end
        tick();
    endtask
`else
    task automatic test_disconnect;
        addr_phase(32'h0000_1000, 4'b1100);
        FRAMEn = 1'b0; IRDYn = 1'b0; CBE = 4'h0;
        tick(); tick();
        L_ACK = 1'b1; L_RDATA = 32'h5566_7788;
        tick();
        L_ACK = 1'b0;
        checks++; if ({TRDYn, STOPn} !== 2'b00 || AD_OUT !== 32'h8877_6655) begin
            failures++; $display("FAIL disc_first got=%b ad=%h exp=00 ad=88776655", {TRDYn, STOPn}, AD_OUT); end
        tick();
        checks++; if ({TRDYn, STOPn, DEVSELn} !== 3'b100 || L_ADDR !== 30'h400) begin
            failures++; $display("FAIL disc_hold got=%b addr=%h exp=100 addr=400", {TRDYn, STOPn, DEVSELn}, L_ADDR); end
        FRAMEn = 1'b1; IRDYn = 1'b1;
        tick();
        checks++; if ({DEVSELn, STOPn, TGT_OE} !== 3'b111) begin
            failures++; $display("FAIL disc_turnaround got=%b exp=111", {DEVSELn, STOPn, TGT_OE}); end
        tick();
    endtask
`endif

    task automatic test_reset_in_data;
        int n;
        addr_phase(32'h0000_1000, 4'b0110);
        FRAMEn = 1'b0; IRDYn = 1'b1; CBE = 4'h0;
        tick(); tick();
        L_ACK = 1'b1; L_RDATA = 32'hCAFE_F00D;
        tick();
        L_ACK = 1'b0;
        checks++; if ({TRDYn, AD_OE} !== 2'b01) begin
            failures++; $display("FAIL rst_pre got=%b exp=01", {TRDYn, AD_OE}); end
        #2 RESETn = 1'b0;
        #1;
        checks++; if ({DEVSELn, TRDYn, STOPn, TGT_OE, AD_OE, L_REQ, L_RnW, TGT_BUSY} !== 8'b1110_0010
                      || L_ADDR !== 30'h0 || AD_OUT !== 32'h0) begin
            failures++; $display("FAIL rst_async got=%b addr=%h ad=%h exp=11100010 addr=0 ad=0",
                {DEVSELn, TRDYn, STOPn, TGT_OE, AD_OE, L_REQ, L_RnW, TGT_BUSY}, L_ADDR, AD_OUT); end
        @(negedge CLK33);
        RESETn = 1'b1; FRAMEn = 1'b1; IRDYn = 1'b1;
        tick();
        addr_phase(32'h0000_0800, 4'b0111);
        FRAMEn = 1'b1; IRDYn = 1'b0; AD_IN = 32'hA1B2_C3D4; CBE = 4'b0101;
        tick(); tick();
        checks++; if ({DEVSELn, L_RnW, TGT_OE} !== 3'b001) begin
            failures++; $display("FAIL rst_redecode got=%b exp=001", {DEVSELn, L_RnW, TGT_OE}); end
        n = 0;
        while (L_REQ !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (L_REQ !== 1'b1 || L_WDATA !== 32'hD4C3_B2A1 || L_BE !== 4'b0101 || L_ADDR !== 30'h200) begin
            failures++; $display("FAIL rst_write got req=%b wd=%h be=%b addr=%h exp req=1 wd=d4c3b2a1 be=0101 addr=200",
                L_REQ, L_WDATA, L_BE, L_ADDR); end
        L_ACK = 1'b1;
        tick();
        L_ACK = 1'b0;
        tick();
        IRDYn = 1'b1;
        tick();
        checks++; if ({TGT_OE, TGT_BUSY, DEVSELn} !== 3'b001) begin
            failures++; $display("FAIL rst_write_end got=%b exp=001", {TGT_OE, TGT_BUSY, DEVSELn}); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_miss();
        test_retry();
`ifdef TARGET_BURST_EN
        test_burst_write();
        test_burst_read();
`else
        test_disconnect();
`endif
        test_reset_in_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
